// File: rtl/regbank_seq.sv
// regbank_seq: sequenced register bank in front of an external ALU.
//
// A request (opcode + up to three addresses) is accepted only in IDLE. LOAD
// writes wdata directly. ADD/SUB/ADDI/SUBI/MUL/DISPLAY read their operands
// onto rd1/rd2 and pulse rsp_valid one cycle after acceptance. Arithmetic
// opcodes then wait for the ALU result on wb_valid/wb_data and write it to
// the latched destination. CLEAR zeroes the whole bank, one entry per cycle.
// Reset enters the same clear sweep, so the bank always starts out zeroed.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid, req_ready  request handshake (ready only in IDLE)
//   opcode                LOAD/ADD/ADDI/SUB/SUBI/MUL/CLEAR/DISPLAY
//   addr1, addr2, addr3   source / destination addresses
//   wdata                 LOAD value
//   rsp_valid, rd1, rd2   one-cycle response pulse with read operands
//   wb_valid, wb_data     ALU write-back
//   busy                  clear sweep in progress
module regbank_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_ADD     = 3'b001,
    OP_ADDI    = 3'b010,
    OP_SUB     = 3'b011,
    OP_SUBI    = 3'b100,
    OP_MUL     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_DISPLAY = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESP    = 2'd1,
    S_WAIT_WB = 2'd2,
    S_CLEAR   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  op_t               op;
  logic              accept;
  logic              rd_accept;
  logic              two_src;
  logic              disp_op;
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] ram [DEPTH];

  assign op        = op_t'(opcode);
  assign accept    = req_valid && (state == S_IDLE);
  assign rd_accept = accept && (op != OP_LOAD) && (op != OP_CLEAR);
  assign two_src   = (op == OP_ADD) || (op == OP_SUB);

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          case (op)
            OP_LOAD:  state_nxt = S_IDLE;
            OP_CLEAR: state_nxt = S_CLEAR;
            default:  state_nxt = S_RESP;
          endcase
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = disp_op ? S_IDLE : S_WAIT_WB;
      end
      S_WAIT_WB: begin
        if (wb_valid) state_nxt = S_IDLE;
      end
      S_CLEAR: begin
        busy = 1'b1;
        if (clr_idx == {ADDR_W{1'b1}}) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers and read operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
      dest    <= '0;
      disp_op <= 1'b0;
      rd1     <= '0;
      rd2     <= '0;
    end else begin
      state <= state_nxt;
      // The index wraps back to 0 after the last entry, ready for the next sweep.
      if (state == S_CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
      if (rd_accept) begin
        rd1     <= ram[addr1];
        rd2     <= two_src ? ram[addr2] : '0;
        dest    <= two_src ? addr3 : addr2;
        disp_op <= (op == OP_DISPLAY);
      end
    end
  end

  // Storage: at most one writer is active in any state, so priority is moot.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_CLEAR)
        ram[clr_idx] <= '0;
      else if (accept && (op == OP_LOAD))
        ram[addr1] <= wdata;
      else if ((state == S_WAIT_WB) && wb_valid)
        ram[dest] <= wb_data;
    end
  end

endmodule

// File: tb/tb_regbank_seq.sv
// Directed bench for regbank_seq: a default 16x16 instance (a_*) and a
// 32-entry, 32-bit instance (b_*), both on one clock.
module tb_regbank_seq;

  localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, ADDI = 3'b010, SUB = 3'b011,
                         SUBI = 3'b100, MUL = 3'b101, CLR = 3'b110, DISP = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n;

  // instance A: DATA_W=16, ADDR_W=4
  logic        a_rst_n = 1'b0, a_req_valid = 1'b0, a_req_ready, a_rsp_valid;
  logic        a_wb_valid = 1'b0, a_busy;
  logic [2:0]  a_opcode = 3'b000;
  logic [3:0]  a_addr1 = '0, a_addr2 = '0, a_addr3 = '0;
  logic [15:0] a_wdata = '0, a_wb_data = '0, a_rd1, a_rd2;

  // instance B: DATA_W=32, ADDR_W=5
  logic        b_rst_n = 1'b0, b_req_valid = 1'b0, b_req_ready, b_rsp_valid;
  logic        b_wb_valid = 1'b0, b_busy;
  logic [2:0]  b_opcode = 3'b000;
  logic [4:0]  b_addr1 = '0, b_addr2 = '0, b_addr3 = '0;
  logic [31:0] b_wdata = '0, b_wb_data = '0, b_rd1, b_rd2;

  regbank_seq dut_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .opcode(a_opcode), .addr1(a_addr1), .addr2(a_addr2), .addr3(a_addr3),
    .wdata(a_wdata), .rsp_valid(a_rsp_valid), .rd1(a_rd1), .rd2(a_rd2),
    .wb_valid(a_wb_valid), .wb_data(a_wb_data), .busy(a_busy)
  );

  regbank_seq #(.DATA_W(32), .ADDR_W(5)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .opcode(b_opcode), .addr1(b_addr1), .addr2(b_addr2), .addr3(b_addr3),
    .wdata(b_wdata), .rsp_valid(b_rsp_valid), .rd1(b_rd1), .rd2(b_rd2),
    .wb_valid(b_wb_valid), .wb_data(b_wb_data), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_a(input logic [2:0] op, input logic [3:0] x1, input logic [3:0] x2,
                       input logic [3:0] x3, input logic [15:0] wd);
    a_opcode = op; a_addr1 = x1; a_addr2 = x2; a_addr3 = x3; a_wdata = wd;
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
  endtask

  task automatic req_b(input logic [2:0] op, input logic [4:0] x1, input logic [31:0] wd);
    b_opcode = op; b_addr1 = x1; b_addr2 = '0; b_addr3 = '0; b_wdata = wd;
    b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0;
  endtask

  // Count cycles while busy stays high; bounded so a stuck sweep cannot hang.
  task automatic count_busy_a(output int cnt);
    cnt = 0;
    while (a_busy && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic count_busy_b(output int cnt);
    cnt = 0;
    while (b_busy && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  // A: write-back of value wd, after which the bank is back in IDLE
  task automatic wb_a(input logic [15:0] wd);
    a_wb_valid = 1'b1; a_wb_data = wd;
    tick();
    a_wb_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", a_busy, 1);
    chk("rst_ready", a_req_ready, 0);
    chk("rst_rsp", a_rsp_valid, 0);
    chk("rst_rd1", a_rd1, 0);
    chk("rst_rd2", a_rd2, 0);
    a_rst_n = 1'b1;
    count_busy_a(n);
    chk("post_rst_sweep_len", n, 16);
    chk("post_rst_ready", a_req_ready, 1);

    req_a(DISP, 4'd5, 4'd0, 4'd0, 16'h0);
    chk("disp_after_rst_rsp", a_rsp_valid, 1);
    chk("disp_after_rst_rd1", a_rd1, 0);
    tick();
    chk("rsp_pulse_one_cycle", a_rsp_valid, 0);

    // LOAD then DISPLAY
    req_a(LOAD, 4'd3, 4'd0, 4'd0, 16'h1234);
    chk("load_no_rsp", a_rsp_valid, 0);
    chk("load_stays_idle", a_req_ready, 1);
    req_a(DISP, 4'd3, 4'd0, 4'd0, 16'h0);
    chk("disp3_rsp", a_rsp_valid, 1);
    chk("disp3_rd1", a_rd1, 16'h1234);
    chk("disp3_rd2", a_rd2, 0);
    tick();
    chk("disp_back_idle", a_req_ready, 1);

    // ADD 1,2,4 with delayed write-back; a request during WAIT_WB is ignored
    req_a(LOAD, 4'd1, 4'd0, 4'd0, 16'd5);
    req_a(LOAD, 4'd2, 4'd0, 4'd0, 16'd7);
    req_a(ADD, 4'd1, 4'd2, 4'd4, 16'h0);
    chk("add_rsp", a_rsp_valid, 1);
    chk("add_rd1", a_rd1, 5);
    chk("add_rd2", a_rd2, 7);
    chk("add_ready_low", a_req_ready, 0);
    tick();
    chk("wait_ready_low", a_req_ready, 0);
    chk("wait_rsp_low", a_rsp_valid, 0);
    tick();
    req_a(LOAD, 4'd4, 4'd0, 4'd0, 16'hAAAA);
    tick();
    chk("wait_still_waiting", a_req_ready, 0);
    wb_a(16'd12);
    chk("wb_back_idle", a_req_ready, 1);
    req_a(DISP, 4'd4, 4'd0, 4'd0, 16'h0);
    chk("disp4_rd1", a_rd1, 12);
    tick(); tick();
    chk("rd1_holds", a_rd1, 12);

    // Write-back onto a source; wb_valid in IDLE ignored
    req_a(ADD, 4'd4, 4'd1, 4'd4, 16'h0);
    chk("alias_rd1", a_rd1, 12);
    chk("alias_rd2", a_rd2, 5);
    tick();
    wb_a(16'd17);
    chk("alias_rd1_unaffected", a_rd1, 12);
    a_wb_valid = 1'b1; a_wb_data = 16'h5555;
    tick();
    a_wb_valid = 1'b0;
    req_a(DISP, 4'd4, 4'd0, 4'd0, 16'h0);
    chk("alias_disp4", a_rd1, 17);
    tick();

    // SUBI 1,9 and MUL 2,10: single-source forms return rd2=0
    req_a(SUBI, 4'd1, 4'd9, 4'd0, 16'h0);
    chk("subi_rd1", a_rd1, 5);
    chk("subi_rd2", a_rd2, 0);
    tick();
    wb_a(16'hFFFB);
    req_a(MUL, 4'd2, 4'd10, 4'd3, 16'h0);
    chk("mul_rd1", a_rd1, 7);
    tick();
    wb_a(16'd35);
    req_a(DISP, 4'd9, 4'd0, 4'd0, 16'h0);
    chk("disp9", a_rd1, 16'hFFFB);
    tick();
    req_a(DISP, 4'd10, 4'd0, 4'd0, 16'h0);
    chk("disp10", a_rd1, 35);
    tick();
    req_a(DISP, 4'd3, 4'd0, 4'd0, 16'h0);
    chk("mul_dest_not_addr3", a_rd1, 16'h1234);
    tick();

    // CLEAR with an ignored request mid-sweep
    req_a(LOAD, 4'd6, 4'd0, 4'd0, 16'd9);
    req_a(CLR, 4'd0, 4'd0, 4'd0, 16'h0);
    chk("clr_busy", a_busy, 1);
    chk("clr_ready_low", a_req_ready, 0);
    a_opcode = LOAD; a_addr1 = 4'd6; a_wdata = 16'h7777;
    n = 0;
    while (a_busy && n < 100) begin
      a_req_valid = (n == 5);
      tick();
      n++;
    end
    a_req_valid = 1'b0;
    chk("clr_sweep_len", n, 16);
    chk("clr_ready_after", a_req_ready, 1);
    req_a(DISP, 4'd6, 4'd0, 4'd0, 16'h0);
    chk("clr_disp6", a_rd1, 0);
    tick();

    // Reset during WAIT_WB discards the destination; reset mid-sweep restarts it
    req_a(SUBI, 4'd2, 4'd8, 4'd0, 16'h0);
    tick();
    a_rst_n = 1'b0;
    tick();
    chk("rst_wait_busy", a_busy, 1);
    chk("rst_wait_ready", a_req_ready, 0);
    chk("rst_wait_rsp", a_rsp_valid, 0);
    a_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1;
    count_busy_a(n);
    chk("rst_mid_sweep_len", n, 16);
    wb_a(16'hFFFF);
    chk("stray_wb_idle", a_req_ready, 1);
    req_a(DISP, 4'd8, 4'd0, 4'd0, 16'h0);
    chk("rst_wait_disp8", a_rd1, 0);
    tick();

    // Instance B: 32 entries, 32-bit data
    b_rst_n = 1'b1;
    count_busy_b(n);
    chk("b_rst_sweep_len", n, 32);
    req_b(LOAD, 5'd31, 32'hDEADBEEF);
    req_b(DISP, 5'd31, 32'h0);
    chk("b_disp31_rsp", b_rsp_valid, 1);
    chk("b_disp31", b_rd1, 32'hDEADBEEF);
    tick();
    req_b(CLR, 5'd0, 32'h0);
    chk("b_clr_busy", b_busy, 1);
    count_busy_b(n);
    chk("b_clr_sweep_len", n, 32);
    req_b(DISP, 5'd31, 32'h0);
    chk("b_disp31_cleared", b_rd1, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regbank_seq.md
REGBANK_SEQ -- requirements
Module: regbank_seq

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; depth DEPTH = 2**ADDR_W entries.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 opcode  in  3  LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111.
REQ-008 addr1, addr2, addr3  in  ADDR_W each  operand and destination addresses.
REQ-009 wdata  in  DATA_W  value stored by LOAD.
REQ-010 rsp_valid  out  1  one-cycle pulse; rd1/rd2 valid.
REQ-011 rd1, rd2  out  DATA_W  read operands.
REQ-012 wb_valid  in  1  ALU result present.
REQ-013 wb_data  in  DATA_W  ALU result to write back.
REQ-014 busy  out  1  clear sweep in progress.

Function
REQ-015 A request SHALL be accepted only in a cycle where req_valid=1 and req_ready=1; requests at other times SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, RESP, WAIT_WB and CLEAR; req_ready SHALL be 1 only in IDLE.
REQ-017 LOAD accepted: ram[addr1] <= wdata at that edge; FSM stays IDLE; no rsp_valid pulse.
REQ-018 ADD/SUB accepted: rd1 <= ram[addr1], rd2 <= ram[addr2], destination latched = addr3; FSM -> RESP.
REQ-019 ADDI/SUBI/MUL accepted: rd1 <= ram[addr1], rd2 <= 0, destination latched = addr2; FSM -> RESP.
REQ-020 DISPLAY accepted: rd1 <= ram[addr1], rd2 <= 0; FSM -> RESP; no write-back follows.
REQ-021 In RESP, rsp_valid SHALL be 1 for exactly that cycle (latency 1 after acceptance); next state is WAIT_WB for arithmetic opcodes and IDLE for DISPLAY.
REQ-022 In WAIT_WB, the first cycle with wb_valid=1 SHALL write wb_data to the latched destination and return to IDLE; the FSM SHALL wait indefinitely otherwise.
REQ-023 wb_valid outside WAIT_WB SHALL be ignored, with no write.
REQ-024 CLEAR accepted: FSM -> CLEAR; one entry per cycle, indices 0..DEPTH-1, is written to 0; after the write of index DEPTH-1, FSM -> IDLE; the sweep takes exactly DEPTH cycles.
REQ-025 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-026 rd1/rd2 SHALL hold their last value until the next read-type acceptance.
REQ-027 A register written in cycle N SHALL return the new value to a read accepted in cycle N+1 or later.
REQ-028 A write-back whose destination equals one of the source addresses SHALL overwrite that source; the already-returned rd1/rd2 SHALL be unaffected.
REQ-029 Addresses SHALL use the full ADDR_W range; there is no out-of-range case.

Reset
REQ-030 rst_n=0 at an edge SHALL force these values: rsp_valid=0, rd1=0, rd2=0, req_ready=0, busy=1, sweep index=0, FSM=CLEAR.
REQ-031 After rst_n returns to 1, the FSM SHALL run the full DEPTH-cycle clear sweep before req_ready rises.
REQ-032 Reset during any state, including mid-sweep or WAIT_WB, SHALL abort the operation, discard the latched destination and restart the sweep from index 0.

Verification
REQ-033 Post-reset (defaults): release rst_n -> busy=1 for 16 cycles, then req_ready=1; DISPLAY of any address -> rd1=0.
REQ-034 LOAD addr1=3 wdata=0x1234, then DISPLAY addr1=3 on the next cycle -> rsp_valid one cycle later, rd1=0x1234, rd2=0.
REQ-035 Set up ram[1]=5 and ram[2]=7, then issue ADD 1,2,4 -> rd1=5, rd2=7, req_ready=0; hold wb_valid low for 3 cycles then assert it with wb_data=12 -> DISPLAY 4 returns 12.
REQ-036 Set up ram[6]=9, then issue CLEAR -> busy=1 for 16 cycles with req_ready=0; a req_valid pulse during the sweep is ignored; afterwards DISPLAY 6 returns 0.
REQ-037 Assert rst_n=0 during WAIT_WB after SUBI 2,8, then after the sweep assert wb_valid=1 with wb_data=0xFFFF -> no write, and ram[8] reads 0.
REQ-038 Instantiate with DATA_W=32 and ADDR_W=5, LOAD addr1=31 wdata=0xDEADBEEF, then CLEAR -> busy=1 for 32 cycles; before the CLEAR, DISPLAY 31 returns 0xDEADBEEF.
